// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer for an external alu1bit slice: one bit pair per step, carry fed back.
// Optional zero-result flag port enabled by defining ALU_SERIAL_ZERO_FLAG_EN.
module alu_serial_seq #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_out,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic             alu_s,
  input  logic             alu_cout
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic             zflag_q, zflag_d;
  logic             zero_q, zero_d;
`endif

  logic last_cnt;
  logic last_bit;

  assign last_cnt = (cnt_q == CW'(SETTLE - 1));
  assign last_bit = (idx_q == IW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      zflag_q  <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      zflag_q  <= zflag_d;
      zero_q   <= zero_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    zflag_d  = zflag_q;
    zero_d   = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = a_in;
          b_d      = b_in;
          op_d     = op_in;
          idx_d    = '0;
          cnt_d    = '0;
          carry_d  = (op_in == 2'b11);
          result_d = '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
          zflag_d  = 1'b1;
`endif
        end
      end
      RUN: begin
        if (last_cnt) begin
          result_d[idx_q] = alu_s;
          carry_d         = alu_cout;
          cnt_d           = '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
          zflag_d         = zflag_q & ~alu_s;
`endif
          if (last_bit) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cout_d  = alu_cout;
            idx_d   = '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            zero_d  = zflag_q & ~alu_s;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slice drive comes only from registered state; IDLE forces it to zero.
  assign busy     = (state_q == RUN);
  assign alu_a    = busy ? a_q[idx_q] : 1'b0;
  assign alu_b    = busy ? b_q[idx_q] : 1'b0;
  assign alu_cin  = busy ? carry_q : 1'b0;
  assign alu_op   = busy ? op_q : 2'b00;
  assign done     = done_q;
  assign result   = result_q;
  assign cout_out = cout_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  assign zero     = zero_q;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: two instances (SETTLE=1 and SETTLE=3), each with a behavioural slice.
module tb_alu_serial_seq;
  localparam int unsigned W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cycles = 0;
  always @(posedge clk) cycles <= cycles + 1;

  int checks = 0;
  int errors = 0;
  int acc[2];

  logic         start1, start3;
  logic [1:0]   op1, op3;
  logic [W-1:0] a1, b1, a3, b3;
  logic         busy1, done1, cout1, aa1, ab1, acin1, as1, acout1;
  logic         busy3, done3, cout3, aa3, ab3, acin3, as3, acout3;
  logic [W-1:0] res1, res3;
  logic [1:0]   aop1, aop3;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic         zero1, zero3;
`endif

  function automatic logic [1:0] slice(input logic [1:0] op, input logic a, b, cin);
    logic [1:0] sum;
    logic       bb;
    bb  = (op == 2'b11) ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {1'b0, cin};
    case (op)
      2'b00:   return {sum[1], ~(a | b)};
      2'b01:   return {sum[1], a ^ b};
      default: return sum;
    endcase
  endfunction

  assign {acout1, as1} = slice(aop1, aa1, ab1, acin1);
  assign {acout3, as3} = slice(aop3, aa3, ab3, acin3);

  alu_serial_seq #(.WIDTH(W), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_in(op1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .result(res1), .cout_out(cout1),
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    .zero(zero1),
`endif
    .alu_a(aa1), .alu_b(ab1), .alu_cin(acin1), .alu_op(aop1), .alu_s(as1), .alu_cout(acout1));

  alu_serial_seq #(.WIDTH(W), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .op_in(op3), .a_in(a3), .b_in(b3),
    .busy(busy3), .done(done3), .result(res3), .cout_out(cout3),
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    .zero(zero3),
`endif
    .alu_a(aa3), .alu_b(ab3), .alu_cin(acin3), .alu_op(aop3), .alu_s(as3), .alu_cout(acout3));

  typedef struct {
    logic         busy, done, cout, z, aa, ab, acin;
    logic [W-1:0] res;
    logic [1:0]   aop;
  } obs_t;

  // Whole-word reference: {cout, result}
  function automatic logic [W:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      2'b00:   return {sum[W], ~(a | b)};
      2'b01:   return {sum[W], a ^ b};
      2'b10:   return sum;
      default: return {1'b0, a} + {1'b0, ~b} + 65'd1;
    endcase
  endfunction

  function automatic logic cin_at(input logic [1:0] op, input logic [W-1:0] a, b, input int i);
    logic [W:0] mask, t, bb;
    mask = (65'd1 << i) - 65'd1;
    bb   = {1'b0, (op == 2'b11) ? ~b : b};
    t    = ({1'b0, a} & mask) + (bb & mask) + ((op == 2'b11) ? 65'd1 : 65'd0);
    return t[i];
  endfunction

  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic get(input int s, output obs_t o);
    if (s == 0) begin
      o.busy = busy1; o.done = done1; o.cout = cout1; o.res = res1;
      o.aa = aa1; o.ab = ab1; o.acin = acin1; o.aop = aop1;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      o.z = zero1;
`else
      o.z = 1'b0;
`endif
    end else begin
      o.busy = busy3; o.done = done3; o.cout = cout3; o.res = res3;
      o.aa = aa3; o.ab = ab3; o.acin = acin3; o.aop = aop3;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      o.z = zero3;
`else
      o.z = 1'b0;
`endif
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic do_start(input int s, input logic [1:0] op, input logic [W-1:0] a, b);
    if (s == 0) begin start1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else        begin start3 = 1'b1; op3 = op; a3 = a; b3 = b; end
    @(negedge clk);
    acc[s] = cycles;
    if (s == 0) begin start1 = 1'b0; op1 = 2'($urandom); a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; end
    else        begin start3 = 1'b0; op3 = 2'($urandom); a3 = {$urandom, $urandom}; b3 = {$urandom, $urandom}; end
  endtask

  task automatic wait_done(input int s, input string tag, input logic [1:0] op, input logic [W-1:0] a, b);
    obs_t       o;
    int         k, settle, bad, idx;
    logic [W:0] exp;
    settle = (s == 0) ? 1 : 3;
    bad    = 0;
    exp    = ref_op(op, a, b);
    forever begin
      get(s, o);
      k = cycles - acc[s];
      if (o.done || k > 2 * int'(W) * settle + 10) break;
      idx = k / settle;
      if (idx < int'(W)) begin
        if (o.busy !== 1'b1 || o.aa !== a[idx] || o.ab !== b[idx] || o.aop !== op ||
            o.acin !== cin_at(op, a, b, idx))
          bad++;
      end else begin
        bad++;
      end
      @(negedge clk);
    end
    chk({tag, ".latency"}, (W + 1)'(k), (W + 1)'(int'(W) * settle));
    chk({tag, ".done"}, (W + 1)'(o.done), (W + 1)'(1));
    chk({tag, ".drive_errs"}, (W + 1)'(bad), '0);
    chk({tag, ".result"}, {o.cout, o.res}, exp);
    chk({tag, ".idle_out"}, (W + 1)'({o.busy, o.aa, o.ab, o.acin, o.aop}), '0);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    chk({tag, ".zero"}, (W + 1)'(o.z), (W + 1)'(exp[W-1:0] == '0));
`endif
  endtask

  task automatic chk_reset_state(input int s, input string tag);
    obs_t o;
    get(s, o);
    chk(tag, {o.busy, o.done, o.cout, o.z, o.aa, o.ab, o.acin, o.aop}, '0);
    chk({tag, ".result"}, {1'b0, o.res}, '0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    obs_t         o;
    rst_n = 1'b0;
    start1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
    start3 = 1'b0; op3 = '0; a3 = '0; b3 = '0;
    repeat (2) @(negedge clk);
    chk_reset_state(0, "reset1");
    chk_reset_state(1, "reset3");
    rst_n = 1'b1;
    @(negedge clk);

    do_start(0, 2'b10, 64'd5, 64'd3);                wait_done(0, "add53", 2'b10, 64'd5, 64'd3);
    do_start(0, 2'b11, 64'd5, 64'd3);                wait_done(0, "sub53", 2'b11, 64'd5, 64'd3);
    do_start(0, 2'b11, 64'd3, 64'd5);                wait_done(0, "sub35", 2'b11, 64'd3, 64'd5);
    do_start(0, 2'b10, '1, 64'd1);                   wait_done(0, "add_ovf", 2'b10, '1, 64'd1);
    do_start(0, 2'b01, 64'hA5, 64'hA5);              wait_done(0, "xor_a5", 2'b01, 64'hA5, 64'hA5);
    do_start(1, 2'b00, '0, '0);                      wait_done(1, "nor_s3", 2'b00, '0, '0);
    ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
    do_start(1, 2'b10, ra, rb);                      wait_done(1, "add_s3", 2'b10, ra, rb);

    // Second start while busy must be ignored.
    ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
    do_start(0, 2'b10, ra, rb);
    repeat (10) @(negedge clk);
    start1 = 1'b1; op1 = 2'b01; a1 = ~ra; b1 = rb ^ 64'h1234;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(0, "busy_start", 2'b10, ra, rb);

    // Back-to-back: start issued in the done cycle.
    ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
    do_start(0, 2'b11, ra, rb);                      wait_done(0, "b2b_first", 2'b11, ra, rb);
    do_start(0, 2'b10, rb, ra);                      wait_done(0, "b2b_second", 2'b10, rb, ra);

    // Asynchronous reset mid-run.
    do_start(0, 2'b10, '1, '1);
    repeat (19) @(negedge clk);
    get(0, o);
    chk("pre_rst.busy_a", (W + 1)'({o.busy, o.aa}), (W + 1)'(2'b11));
    #2 rst_n = 1'b0;
    #1 chk_reset_state(0, "midrun_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    get(0, o);
    chk("post_rst.done", (W + 1)'({o.busy, o.done}), '0);
    do_start(0, 2'b10, 64'd5, 64'd3);                wait_done(0, "after_rst", 2'b10, 64'd5, 64'd3);

    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rop = 2'($urandom_range(0, 3));
      do_start(0, rop, ra, rb);                      wait_done(0, "rand1", rop, ra, rb);
    end
    for (int i = 0; i < 2; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rop = 2'($urandom_range(0, 3));
      do_start(1, rop, ra, rb);                      wait_done(1, "rand3", rop, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
